// File: rtl/sdf_scene_pipe_if.sv
// Signal bundle for sdf_scene_pipe: point input stream, primitive side-channel and
// combined-distance output stream.
interface sdf_scene_pipe_if #(
    parameter int TAG_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [26:0]      i_point_x;
    logic [26:0]      i_point_y;
    logic [26:0]      i_point_z;
    logic [TAG_W-1:0] i_tag;
    logic [2:0]       i_mode;
    logic [26:0]      o_pt_x;
    logic [26:0]      o_pt_y;
    logic [26:0]      o_pt_z;
    logic             o_pt_valid;
    logic [26:0]      i_dist_a;
    logic [26:0]      i_dist_b;
    logic             o_valid;
    logic             i_ready;
    logic [26:0]      o_dist;
    logic [TAG_W-1:0] o_tag;
    logic [2:0]       o_mode;
    logic             o_busy;

    modport slave (
        input  i_valid, i_point_x, i_point_y, i_point_z, i_tag, i_mode,
        input  i_dist_a, i_dist_b, i_ready,
        output o_ready, o_pt_x, o_pt_y, o_pt_z, o_pt_valid,
        output o_valid, o_dist, o_tag, o_mode, o_busy
    );

    modport master (
        output i_valid, i_point_x, i_point_y, i_point_z, i_tag, i_mode,
        output i_dist_a, i_dist_b, i_ready,
        input  o_ready, o_pt_x, o_pt_y, o_pt_z, o_pt_valid,
        input  o_valid, o_dist, o_tag, o_mode, o_busy
    );
endinterface

// File: rtl/sdf_scene_pipe.sv
// SDF scene combiner: issues points to two fixed-latency primitives, aligns their
// distances, combines them per mode and buffers results in a credit-managed FIFO.
module sdf_scene_pipe #(
    parameter int TAG_W      = 8,
    parameter int LAT_A      = 9,
    parameter int LAT_B      = 11,
    parameter int FIFO_DEPTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    sdf_scene_pipe_if.slave bus
);
    localparam int L  = (LAT_A > LAT_B) ? LAT_A : LAT_B;
    localparam int DA = L - LAT_A;
    localparam int DB = L - LAT_B;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_t;

    // Sign-magnitude "a < b" on raw patterns; both zeros compare equal
    function automatic logic sm_less(input logic [26:0] a, input logic [26:0] b);
        logic res;
        if ((a[25:0] == 26'd0) && (b[25:0] == 26'd0)) begin
            res = 1'b0;
        end else if (a[26] != b[26]) begin
            res = a[26];
        end else if (a[26] == 1'b0) begin
            res = (a[25:0] < b[25:0]);
        end else begin
            res = (a[25:0] > b[25:0]);
        end
        return res;
    endfunction

    function automatic logic [26:0] combine(input logic [2:0] mode, input logic [26:0] a,
                                            input logic [26:0] b);
        logic [26:0] nb;
        logic [26:0] res;
        nb = {~b[26], b[25:0]};
        case (mode)
            3'd0:    res = a;
            3'd1:    res = b;
            3'd3:    res = sm_less(a, b) ? b : a;
            3'd4:    res = sm_less(a, nb) ? nb : a;
            default: res = sm_less(b, a) ? b : a;
        endcase
        return res;
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [2:0]         mode_r;
    logic               ready_en_r;
    logic [CW-1:0]      inflight_r;
    logic [CW-1:0]      inflight_nx_s;
    logic [CW-1:0]      fifo_cnt_r;
    logic [CW-1:0]      fifo_cnt_nx_s;
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW-1:0]      rd_ptr_nx_s;
    logic [CW:0]        credit_sum_s;
    logic               ready_s;
    logic               accept_s;
    logic               wr_s;
    logic               rd_s;
    logic [L-1:0]       vld_sr_r;
    logic [TAG_W-1:0]   tag_sr_r [L];
    logic [26:0]        dist_a_al_s;
    logic [26:0]        dist_b_al_s;
    logic               comb_vld_r;
    logic [26:0]        comb_dist_r;
    logic [TAG_W-1:0]   comb_tag_r;
    logic [TAG_W+26:0]  mem_r [FIFO_DEPTH];
    logic [TAG_W+26:0]  head_s;
    logic               out_valid_r;
    logic [26:0]        out_dist_r;
    logic [TAG_W-1:0]   out_tag_r;
    logic               busy_r;

    assign credit_sum_s = {1'b0, inflight_r} + {1'b0, fifo_cnt_r};
    assign ready_s      = ready_en_r && (state_r == RUN) && (credit_sum_s < DEPTH_V);
    assign accept_s     = bus.i_valid && ready_s;
    assign wr_s         = comb_vld_r;
    assign rd_s         = out_valid_r && bus.i_ready;

    assign bus.o_ready    = ready_s;
    assign bus.o_pt_x     = bus.i_point_x;
    assign bus.o_pt_y     = bus.i_point_y;
    assign bus.o_pt_z     = bus.i_point_z;
    assign bus.o_pt_valid = accept_s;
    assign bus.o_valid    = out_valid_r;
    assign bus.o_dist     = out_dist_r;
    assign bus.o_tag      = out_tag_r;
    assign bus.o_mode     = mode_r;
    assign bus.o_busy     = busy_r;

    // Mode-change sequencer next state
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            RUN: begin
                if (bus.i_mode != mode_r) state_nx_s = DRAIN;
                else state_nx_s = RUN;
            end
            DRAIN: begin
                if (inflight_r == {CW{1'b0}}) state_nx_s = APPLY;
                else state_nx_s = DRAIN;
            end
            APPLY:   state_nx_s = RUN;
            default: state_nx_s = RUN;
        endcase
    end

    // Occupancy bookkeeping and the next FIFO head (write bypass when the FIFO drains)
    always_comb begin
        inflight_nx_s = inflight_r + {{(CW-1){1'b0}}, accept_s} - {{(CW-1){1'b0}}, wr_s};
        fifo_cnt_nx_s = fifo_cnt_r + {{(CW-1){1'b0}}, wr_s} - {{(CW-1){1'b0}}, rd_s};
        rd_ptr_nx_s   = rd_ptr_r + {{(AW-1){1'b0}}, rd_s};
        if (wr_s && (wr_ptr_r == rd_ptr_nx_s)) begin
            head_s = {comb_tag_r, comb_dist_r};
        end else begin
            head_s = mem_r[rd_ptr_nx_s];
        end
    end

    // Startup gate, FSM register and the applied combine mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
            state_r    <= RUN;
            mode_r     <= 3'd2;
        end else begin
            ready_en_r <= 1'b1;
            state_r    <= state_nx_s;
            if (state_r == APPLY) mode_r <= bus.i_mode;
            else mode_r <= mode_r;
        end
    end

    // Counters, FIFO pointers and registered output view of the FIFO head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= {CW{1'b0}};
            fifo_cnt_r  <= {CW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            out_valid_r <= 1'b0;
            out_dist_r  <= 27'd0;
            out_tag_r   <= {TAG_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            inflight_r  <= inflight_nx_s;
            fifo_cnt_r  <= fifo_cnt_nx_s;
            wr_ptr_r    <= wr_ptr_r + {{(AW-1){1'b0}}, wr_s};
            rd_ptr_r    <= rd_ptr_nx_s;
            out_valid_r <= (fifo_cnt_nx_s != {CW{1'b0}});
            out_dist_r  <= head_s[26:0];
            out_tag_r   <= head_s[TAG_W+26:27];
            busy_r      <= (inflight_nx_s != {CW{1'b0}}) || (fifo_cnt_nx_s != {CW{1'b0}});
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_s) mem_r[wr_ptr_r] <= {comb_tag_r, comb_dist_r};
        else mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end

    // Valid/tag shadow of the primitive pipelines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_r <= {L{1'b0}};
            for (int i = 0; i < L; i++) tag_sr_r[i] <= {TAG_W{1'b0}};
        end else begin
            vld_sr_r[0] <= accept_s;
            tag_sr_r[0] <= bus.i_tag;
            for (int i = 1; i < L; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
                tag_sr_r[i] <= tag_sr_r[i-1];
            end
        end
    end

    generate
        if (DA == 0) begin : g_a_direct
            assign dist_a_al_s = bus.i_dist_a;
        end else begin : g_a_delay
            logic [26:0] dly_r [DA];
            // Pads the faster primitive A up to the common latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DA; i++) dly_r[i] <= 27'd0;
                end else begin
                    dly_r[0] <= bus.i_dist_a;
                    for (int i = 1; i < DA; i++) dly_r[i] <= dly_r[i-1];
                end
            end
            assign dist_a_al_s = dly_r[DA-1];
        end
        if (DB == 0) begin : g_b_direct
            assign dist_b_al_s = bus.i_dist_b;
        end else begin : g_b_delay
            logic [26:0] dly_r [DB];
            // Pads the faster primitive B up to the common latency
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DB; i++) dly_r[i] <= 27'd0;
                end else begin
                    dly_r[0] <= bus.i_dist_b;
                    for (int i = 1; i < DB; i++) dly_r[i] <= dly_r[i-1];
                end
            end
            assign dist_b_al_s = dly_r[DB-1];
        end
    endgenerate

    // Combine stage; mode_r cannot change while samples are in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comb_vld_r  <= 1'b0;
            comb_dist_r <= 27'd0;
            comb_tag_r  <= {TAG_W{1'b0}};
        end else begin
            comb_vld_r  <= vld_sr_r[L-1];
            comb_dist_r <= combine(mode_r, dist_a_al_s, dist_b_al_s);
            comb_tag_r  <= tag_sr_r[L-1];
        end
    end
endmodule

// File: doc/sdf_scene_pipe.md
SDF_SCENE_PIPE -- requirements
Module: sdf_scene_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
- TAG_W, default 8: width of the per-sample tag carried alongside each point.
- LAT_A, default 9: fixed latency of external primitive A, from o_pt_valid to i_dist_a.
- LAT_B, default 11: fixed latency of external primitive B, from o_pt_valid to i_dist_b.
- FIFO_DEPTH, default 16: output FIFO entries; power of two; at least max(LAT_A,LAT_B)+2.

REQ-002 Ports SHALL be, as name, direction, width, meaning (clock and reset first):
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- i_valid, in, 1: input point valid.
- o_ready, out, 1: block accepts a point this cycle.
- i_point_x, i_point_y, i_point_z, in, 27 each: point, 27-bit float {sign[26], exp[25:18], man[17:0]}.
- i_tag, in, TAG_W: sample identifier.
- i_mode, in, 3: requested combine mode.
- o_pt_x, o_pt_y, o_pt_z, out, 27 each: point driven to both primitives.
- o_pt_valid, out, 1: point issued to the primitives.
- i_dist_a, in, 27: distance returned by primitive A.
- i_dist_b, in, 27: distance returned by primitive B.
- o_valid, out, 1: output distance valid.
- i_ready, in, 1: downstream accepts the output.
- o_dist, out, 27: combined distance.
- o_tag, out, TAG_W: tag matching o_dist.
- o_mode, out, 3: mode currently in effect.
- o_busy, out, 1: samples are in flight or the FIFO is non-empty.

Function
REQ-003 An accept SHALL occur on any edge where i_valid and o_ready are both 1. On an accept, o_pt_* SHALL equal i_point_* combinationally and o_pt_valid SHALL be 1; otherwise o_pt_valid SHALL be 0.
REQ-004 With L = max(LAT_A,LAT_B), the block SHALL delay i_dist_a by L-LAT_A stages and i_dist_b by L-LAT_B stages, so both operands align at cycle k+L for an accept at edge k.
REQ-005 Valid bits and tags SHALL travel through an L-stage shift register parallel to the data, with no gaps and no reordering.
REQ-006 The combine stage SHALL be one registered stage, writing the FIFO at k+L+1. The FIFO SHALL be show-ahead, so o_valid rises at k+L+2 when the FIFO was empty.
REQ-007 The combine SHALL use o_mode, with all operations on raw bit patterns:
- 0: A.
- 1: B.
- 2: union, min(A,B).
- 3: intersection, max(A,B).
- 4: difference, max(A,-B), where -B inverts bit 26.
- 5 to 7: reserved, treated as 2.
REQ-008 min and max SHALL use sign-magnitude ordering on the full 27-bit pattern. +0 and -0 SHALL compare equal. On a tie, operand A SHALL be returned. NaN and Inf SHALL receive no special handling.
REQ-009 Credit rule: o_ready = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH).
- inflight counts accepted samples not yet written to the FIFO.
- The FIFO SHALL never overflow. Write and read in the same cycle SHALL be legal at any fill level.
REQ-010 The FIFO SHALL pop on o_valid && i_ready. o_dist and o_tag SHALL hold stable while o_valid=1 and i_ready=0.
REQ-011 The FSM SHALL have three states, RUN, DRAIN and APPLY:
- RUN to DRAIN when i_mode != o_mode.
- DRAIN to APPLY when inflight==0; the FIFO need not be empty.
- APPLY: o_mode <= i_mode sampled that cycle, then return to RUN next cycle.
- o_ready SHALL be 0 in DRAIN and APPLY.
REQ-012 If i_mode changes again during DRAIN, the value sampled in APPLY SHALL win. If i_mode returns to o_mode during DRAIN, the FSM SHALL still pass through APPLY, which is a no-op.
REQ-013 Samples accepted before a mode change SHALL be combined with the old mode. Samples accepted after it SHALL use the new mode. No sample may mix modes.
REQ-014 o_busy SHALL be (inflight != 0) || (fifo_count != 0).

Reset
REQ-015 While rst_n=0, the following SHALL clear asynchronously: all pipeline valid bits, inflight, the FIFO pointers and count, o_valid, o_pt_valid, o_busy, o_dist, o_tag. o_mode SHALL reset to 2 and the state to RUN.
REQ-016 o_ready SHALL be 0 during reset and SHALL assert on the first edge after rst_n rises.
REQ-017 Reset mid-operation SHALL discard all in-flight and buffered samples. Primitive outputs arriving after reset SHALL be ignored, because their valid bits are cleared.

Verification
REQ-018 Single sample: defaults, mode 2, A=0x1FC0000 (+1.0), B=0x5FC0000 (-1.0), accept at edge 0 -> o_valid at edge 13, o_dist=0x5FC0000, tag echoed.
REQ-019 Back-to-back: 40 accepts with i_ready=1 -> 40 outputs in order with contiguous tags and o_ready constantly 1.
REQ-020 Backpressure: i_ready=0 with a continuous offer -> exactly 16 accepts, then o_ready=0. Releasing i_ready -> all 16 outputs, no loss or duplication.
REQ-021 Mode change: i_mode 2->4 after 5 accepts -> o_ready low until those 5 leave the pipeline. The 5 outputs use union. Next sample with A=+1.0, B=+2.0 -> o_dist = max(1.0, -2.0) = 0x1FC0000.
REQ-022 Tie and zero: A=0x0000000, B=0x4000000 (-0) in mode 2 -> o_dist=0x0000000.
REQ-023 Reset with 6 samples in flight and 3 buffered -> o_valid=0 immediately, o_mode=2, no stale output afterwards.
